// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: registers a command onto the ALU inputs, waits SETTLE
// cycles, captures result/flags, and returns them over a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 6,
    parameter int OPW    = 2,
    parameter int FLAGW  = 4,
    parameter int SETTLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_arg0,
    input  logic [WIDTH-1:0] i_cmd_arg1,
    input  logic [OPW-1:0]   i_cmd_oper,
    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [OPW-1:0]   o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [FLAGW-1:0] i_alu_flag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [FLAGW-1:0] o_rsp_flag,
    output logic [OPW-1:0]   o_rsp_oper,
    output logic [7:0]       o_txn_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [3:0]         settle_q, settle_d;
    logic [WIDTH-1:0]   alu_arg0_q, alu_arg0_d;
    logic [WIDTH-1:0]   alu_arg1_q, alu_arg1_d;
    logic [OPW-1:0]     alu_oper_q, alu_oper_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [FLAGW-1:0]   rsp_flag_q, rsp_flag_d;
    logic [OPW-1:0]     rsp_oper_q, rsp_oper_d;
    logic [7:0]         txn_q, txn_d;

    // State and datapath registers; reset discards any in-flight command.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            alu_arg0_q   <= '0;
            alu_arg1_q   <= '0;
            alu_oper_q   <= '0;
            rsp_result_q <= '0;
            rsp_flag_q   <= '0;
            rsp_oper_q   <= '0;
            txn_q        <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            alu_arg0_q   <= alu_arg0_d;
            alu_arg1_q   <= alu_arg1_d;
            alu_oper_q   <= alu_oper_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_oper_q   <= rsp_oper_d;
            txn_q        <= txn_d;
        end
    end

    // Next-state logic: accept in IDLE, count down settle in ISSUE, hold in RESP.
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        alu_arg0_d   = alu_arg0_q;
        alu_arg1_d   = alu_arg1_q;
        alu_oper_d   = alu_oper_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_oper_d   = rsp_oper_q;
        txn_d        = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    alu_arg0_d = i_cmd_arg0;
                    alu_arg1_d = i_cmd_arg1;
                    alu_oper_d = i_cmd_oper;
                    settle_d   = SETTLE_LOAD;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (settle_q == 4'd0) begin
                    rsp_result_d = i_alu_result;
                    rsp_flag_d   = i_alu_flag;
                    rsp_oper_d   = alu_oper_q;
                    state_d      = ST_RESP;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    txn_d   = txn_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_cmd_ready  = (state_q == ST_IDLE);
    assign o_rsp_valid  = (state_q == ST_RESP);
    assign o_alu_arg0   = alu_arg0_q;
    assign o_alu_arg1   = alu_arg1_q;
    assign o_alu_oper   = alu_oper_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_flag   = rsp_flag_q;
    assign o_rsp_oper   = rsp_oper_q;
    assign o_txn_cnt    = txn_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: adder ALU stub, scoreboard on the response
// channel, directed steps for reset, stall, settle timing and counter wrap.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         pops = 0;

    always #5 clk = ~clk;

    // Cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT1: SETTLE = 1 ----------------
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [5:0] cmd_arg0, cmd_arg1, alu_arg0, alu_arg1, alu_res, rsp_result;
    logic [1:0] cmd_oper, alu_oper, rsp_oper;
    logic [3:0] alu_flag, rsp_flag;
    logic [7:0] txn_cnt;

    assign alu_res  = alu_arg0 + alu_arg1;
    assign alu_flag = {3'b000, alu_res[5]};

    alu_cmd_sequencer #(.WIDTH(6), .OPW(2), .FLAGW(4), .SETTLE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_arg0(cmd_arg0), .i_cmd_arg1(cmd_arg1), .i_cmd_oper(cmd_oper),
        .o_alu_arg0(alu_arg0), .o_alu_arg1(alu_arg1), .o_alu_oper(alu_oper),
        .i_alu_result(alu_res), .i_alu_flag(alu_flag),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_flag(rsp_flag), .o_rsp_oper(rsp_oper),
        .o_txn_cnt(txn_cnt)
    );

    // ---------------- DUT2: SETTLE = 4 ----------------
    logic       cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, bad2;
    logic [5:0] cmd2_arg0, cmd2_arg1, alu2_arg0, alu2_arg1, alu2_res, rsp2_result;
    logic [1:0] cmd2_oper, alu2_oper, rsp2_oper;
    logic [3:0] alu2_flag, rsp2_flag;
    logic [7:0] txn2_cnt;

    // Stub output is corrupted while bad2 is set, modelling an ALU still settling.
    assign alu2_res  = (alu2_arg0 + alu2_arg1) ^ (bad2 ? 6'h2A : 6'h00);
    assign alu2_flag = {3'b000, alu2_res[5]};

    alu_cmd_sequencer #(.WIDTH(6), .OPW(2), .FLAGW(4), .SETTLE(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid2), .o_cmd_ready(cmd_ready2),
        .i_cmd_arg0(cmd2_arg0), .i_cmd_arg1(cmd2_arg1), .i_cmd_oper(cmd2_oper),
        .o_alu_arg0(alu2_arg0), .o_alu_arg1(alu2_arg1), .o_alu_oper(alu2_oper),
        .i_alu_result(alu2_res), .i_alu_flag(alu2_flag),
        .o_rsp_valid(rsp_valid2), .i_rsp_ready(rsp_ready2),
        .o_rsp_result(rsp2_result), .o_rsp_flag(rsp2_flag), .o_rsp_oper(rsp2_oper),
        .o_txn_cnt(txn2_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- Scoreboard for DUT1 ----------------
    typedef struct packed {
        logic [5:0] res;
        logic [3:0] flag;
        logic [1:0] op;
    } exp_t;

    exp_t       sb[$];
    exp_t       sb_e;
    logic [5:0] sb_sum;

    // Push the model result at each accept, pop and compare at each response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 1);
                end else begin
                    sb_e = sb.pop_front();
                    pops++;
                    check("rsp_result", 32'(rsp_result), 32'(sb_e.res));
                    check("rsp_flag",   32'(rsp_flag),   32'(sb_e.flag));
                    check("rsp_oper",   32'(rsp_oper),   32'(sb_e.op));
                end
            end
            if (cmd_valid && cmd_ready) begin
                sb_sum = cmd_arg0 + cmd_arg1;
                sb.push_back('{res: sb_sum, flag: {3'b000, sb_sum[5]}, op: cmd_oper});
            end
        end
    end

    task automatic wait_rsp1(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rsp_valid && n < 64);
    endtask

    task automatic send1(input logic [5:0] a0, input logic [5:0] a1, input logic [1:0] op);
        cmd_arg0  = a0;
        cmd_arg1  = a1;
        cmd_oper  = op;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"},  32'(cmd_ready), 1);
        check({tag, "_rsp_valid"},  32'(rsp_valid), 0);
        check({tag, "_alu_arg0"},   32'(alu_arg0), 0);
        check({tag, "_alu_arg1"},   32'(alu_arg1), 0);
        check({tag, "_alu_oper"},   32'(alu_oper), 0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 0);
        check({tag, "_rsp_flag"},   32'(rsp_flag), 0);
        check({tag, "_rsp_oper"},   32'(rsp_oper), 0);
        check({tag, "_txn_cnt"},    32'(txn_cnt), 0);
    endtask

    int n;
    int acc;
    int prev;

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0; cmd_arg0  = '0; cmd_arg1  = '0; cmd_oper  = '0; rsp_ready  = 1'b0;
        cmd_valid2 = 1'b0; cmd2_arg0 = '0; cmd2_arg1 = '0; cmd2_oper = '0; rsp_ready2 = 1'b0;
        bad2       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        check("rst_cmd_ready2", 32'(cmd_ready2), 1);
        check("rst_txn_cnt2",   32'(txn2_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2 + 13, oper 0, consumer ready
        rsp_ready = 1'b1;
        send1(6'd2, 6'd13, 2'd0);
        check("a_alu_arg0", 32'(alu_arg0), 2);
        check("a_alu_arg1", 32'(alu_arg1), 13);
        wait_rsp1(n);
        check("a_latency", n, 1);
        @(posedge clk); #1;
        check("a_txn_cnt",   32'(txn_cnt), 1);
        check("a_cmd_ready", 32'(cmd_ready), 1);

        // 17 + 18 wraps to -29 with negative flag
        send1(6'd17, 6'd18, 2'd0);
        wait_rsp1(n);
        check("b_latency",  n, 1);
        check("b_result",   32'(rsp_result), 32'h23);
        check("b_flag",     32'(rsp_flag), 1);
        @(posedge clk); #1;
        check("b_txn_cnt", 32'(txn_cnt), 2);

        // Stall with consumer not ready; competing command must be ignored
        rsp_ready = 1'b0;
        send1(6'd5, 6'd2, 2'd3);
        wait_rsp1(n);
        check("s_latency", n, 1);
        cmd_arg0  = 6'd9;
        cmd_arg1  = 6'd9;
        cmd_oper  = 2'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("s_rsp_valid",  32'(rsp_valid), 1);
            check("s_result",     32'(rsp_result), 7);
            check("s_flag",       32'(rsp_flag), 0);
            check("s_oper",       32'(rsp_oper), 3);
            check("s_cmd_ready",  32'(cmd_ready), 0);
            check("s_alu_arg0",   32'(alu_arg0), 5);
            check("s_txn_cnt",    32'(txn_cnt), 2);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("s_txn_after", 32'(txn_cnt), 3);
        check("s_ready_after", 32'(cmd_ready), 1);

        // Reset asserted while in ISSUE
        send1(6'd10, 6'd11, 2'd1);
        check("r_in_issue_ready", 32'(cmd_ready), 0);
        check("r_in_issue_valid", 32'(rsp_valid), 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("r_post_valid", 32'(rsp_valid), 0);
        check("r_post_txn",   32'(txn_cnt), 0);
        check("r_post_ready", 32'(cmd_ready), 1);

        // SETTLE = 4: capture must see the stub value at the 4th cycle, not earlier
        rsp_ready2 = 1'b1;
        cmd2_arg0  = 6'd3;
        cmd2_arg1  = 6'd1;
        cmd2_oper  = 2'd2;
        cmd_valid2 = 1'b1;
        @(posedge clk); #1;
        cmd_valid2 = 1'b0;
        bad2 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 2) bad2 = 1'b0;
        end while (!rsp_valid2 && n < 64);
        check("t_latency", n, 4);
        check("t_result",  32'(rsp2_result), 4);
        check("t_flag",    32'(rsp2_flag), 0);
        check("t_oper",    32'(rsp2_oper), 2);
        @(posedge clk); #1;
        check("t_txn_cnt",   32'(txn2_cnt), 1);
        check("t_cmd_ready", 32'(cmd_ready2), 1);

        // 256 back-to-back commands on DUT1
        pops      = 0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        prev      = 0;
        for (int i = 0; i < 256; i++) begin
            cmd_arg0 = 6'(i);
            cmd_arg1 = 6'(i * 7);
            cmd_oper = 2'(i);
            n = 0;
            while (!cmd_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk);
            acc = cyc;
            #1;
            if (i > 0) check("w_spacing", acc - prev, 3);
            prev = acc;
        end
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("w_pops",     pops, 256);
        check("w_sb_empty", 32'(sb.size()), 0);
        check("w_txn_wrap", 32'(txn_cnt), 0);
        check("w_ready",    32'(cmd_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential front-end for the 6-bit signed combinational ALU in the communication unit. Accepts operation commands over a valid/ready handshake and drives the ALU operand and operation inputs from registers. After a configurable settle time it captures the ALU result and flags. It then returns them, together with the echoed operation code and a transaction count, over a second valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 6: operand and result width (two's complement).
- `OPW`, 2: operation code width.
- `FLAGW`, 4: ALU flag vector width.
- `SETTLE`, 1: clock cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- `i_clk` input 1: single clock; all state updates on the rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_cmd_valid` input 1: command present.
- `o_cmd_ready` output 1: block can accept a command.
- `i_cmd_arg0`, `i_cmd_arg1` input WIDTH: signed operands.
- `i_cmd_oper` input OPW: operation code, passed to the ALU unmodified.
- `o_alu_arg0`, `o_alu_arg1` output WIDTH: registered operands to the ALU.
- `o_alu_oper` output OPW: registered operation code to the ALU.
- `i_alu_result` input WIDTH: ALU result.
- `i_alu_flag` input FLAGW: ALU flags.
- `o_rsp_valid` output 1: response present.
- `i_rsp_ready` input 1: consumer accepts the response.
- `o_rsp_result` output WIDTH: captured result.
- `o_rsp_flag` output FLAGW: captured flags.
- `o_rsp_oper` output OPW: operation code of this response.
- `o_txn_cnt` output 8: count of completed responses; wraps 255 -> 0.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- `o_cmd_ready` = (state == IDLE). `o_rsp_valid` = (state == RESP).
- IDLE:
  - On `i_cmd_valid && o_cmd_ready`, register the three command fields into `o_alu_*`.
  - Load the settle counter with SETTLE-1 and go to ISSUE.
- ISSUE:
  - If the settle counter is 0, capture `i_alu_result`, `i_alu_flag` and `o_alu_oper` into the `o_rsp_*` registers, then go to RESP.
  - Otherwise decrement the settle counter.
  - `i_cmd_valid` is ignored in this state.
- RESP:
  - `o_rsp_*` is held stable.
  - On `i_rsp_ready`: increment `o_txn_cnt` and go to IDLE.
- The `o_alu_*` registers keep their last command until the next accept. They are not cleared on return to IDLE.
- No arithmetic is performed in this block. The result and flags are captured bit-exact. Width wrap is the ALU's responsibility.
- Reset mid-operation: every register returns to its reset value immediately. An in-flight command is discarded and not counted.

## Timing
- Reset values:
  - state IDLE, so `o_cmd_ready`=1 and `o_rsp_valid`=0.
  - `o_alu_arg0`, `o_alu_arg1`, `o_alu_oper` = 0.
  - `o_rsp_result`, `o_rsp_flag`, `o_rsp_oper` = 0.
  - `o_txn_cnt` = 0; settle counter = 0.
- The command is accepted at edge k. The ALU inputs are valid after edge k.
- Capture happens at edge k+SETTLE. `o_rsp_valid` is high after edge k+SETTLE.
- Latency from accept to response valid is SETTLE cycles.
- If `i_rsp_ready` is already high, the response is consumed at edge k+SETTLE+1. `o_cmd_ready` returns high after that edge.
- Maximum throughput is one command per SETTLE+2 cycles. The block never accepts a command in the same cycle a response is consumed.
- Holding `i_rsp_ready` low stalls the block indefinitely. Result, flags, oper and count stay unchanged.
- `o_txn_cnt` updates on the edge the response handshake completes.

## Test plan
The bench ALU stub returns result = arg0+arg1 with 6-bit wrap and flag = {3'b000, result<0}. SETTLE=1 unless stated.
- Reset -> `o_cmd_ready`=1, `o_rsp_valid`=0, all data outputs 0, `o_txn_cnt`=0. Reassert reset while in ISSUE -> same values, and the count is not incremented.
- Command arg0=2, arg1=13, oper=0, with `i_rsp_ready`=1 -> `o_rsp_valid` high exactly 1 cycle after accept, result=15, flag=0, oper=0, `o_txn_cnt`=1.
- Command 17+18, oper=0 -> result=-29 (wrap of 35), flag=4'b0001.
- Command arg0=5, arg1=2, oper=3, with `i_rsp_ready` held low for 5 cycles -> response (result=7, flag=0, oper=3) stable throughout, `o_cmd_ready`=0, and a second command presented in that window is not accepted.
- SETTLE=4: command arg0=3, arg1=1, oper=2 -> `o_rsp_valid` rises 4 cycles after accept, result=4, oper=2. The stub changes its output after 2 cycles and the captured value reflects the value at cycle 4.
- 256 back-to-back commands with `i_cmd_valid` and `i_rsp_ready` always high -> `o_txn_cnt` wraps to 0, accepts are spaced SETTLE+2 cycles apart, and no command is lost or duplicated.
